alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Sequences 8-bit ALU commands. It powers up the external ALU and issues one
// operation at a time. It then captures the ALU result and its error flag, and
// returns them as a one-cycle res_valid pulse. The ISSUE to res_valid latency
// is three cycles.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; a command is accepted when
//                              both are high at a clock edge
//   cmd_op, cmd_chain,         opcode (AND,OR,NOT,XOR,ADD,SUB,MULT,CLEAR),
//   cmd_a, cmd_b               chain select, operands A and B
//   alu_on, alu_in_sel,        drive to the ALU: power, one-hot {persist,load,reset},
//   alu_num1, alu_num2,        operands, one-hot {and,or,not,xor,add,sub,mult}
//   alu_out_sel
//   alu_result, alu_state      ALU response (state 00 off, 01 ready, 10 run, 11 error)
//   res_valid, res_data,       result pulse, held result data, and error
//   res_err                    (res_err is qualified by res_valid)
//   busy                       low only when idle with nothing queued
//
// Build option
//   ALU_SEQ_FIFO_EN  When defined, a FIFO_DEPTH-entry command FIFO is used,
//                    with cmd_ready = !full. When undefined, there is a single
//                    holding register, and commands are accepted only in IDLE.
//
// state   | meaning
// PWRUP   | ALU powered and held in reset until it reports ready
// IDLE    | waiting for a command
// ISSUE   | operands and operation presented, ALU loads (CLEAR resets it)
// CAPTURE | ALU result registered
// CHECK   | ALU error status sampled
// DONE    | result published for one cycle
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_chain,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       alu_on,
    output logic [2:0] alu_in_sel,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [6:0] alu_out_sel,
    input  logic [7:0] alu_result,
    input  logic [1:0] alu_state,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy
);

    localparam logic [2:0] OP_CLEAR    = 3'd7;
    localparam logic [1:0] ALU_OFF     = 2'b00;
    localparam logic [1:0] ALU_READY   = 2'b01;
    localparam logic [1:0] ALU_RUN_ERR = 2'b11;
    localparam int         CMD_W       = 20;

    typedef enum logic [2:0] {PWRUP, IDLE, ISSUE, CAPTURE, CHECK, DONE} stateT;

    stateT            state, nextState;
    logic             rstQ;
    logic             takeCmd, cmdAvail, cmdQueued, aluOff;
    logic [CMD_W-1:0] cmdWord, headCmd;
    logic [2:0]       curOp;
    logic             curChain;
    logic [7:0]       curA, curB;
    logic [7:0]       captureQ, resDataQ, chainQ, opA;
    logic             resErrQ;
    logic [6:0]       opSel;

    assign aluOff  = (alu_state == ALU_OFF);
    assign cmdWord = {cmd_op, cmd_chain, cmd_a, cmd_b};

`ifdef ALU_SEQ_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [CMD_W-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   fifoCount;
    logic             fifoFull, fifoEmpty, enq;

    assign fifoFull  = (fifoCount == (PTR_W+1)'(FIFO_DEPTH));
    assign fifoEmpty = (fifoCount == '0);
    assign cmd_ready = !rstQ && !fifoFull;
    assign enq       = cmd_valid && cmd_ready;
    assign cmdAvail  = !fifoEmpty;
    assign cmdQueued = !fifoEmpty;
    assign headCmd   = fifoMem[rdPtr];

    always_ff @(posedge clk) begin
        if (enq) fifoMem[wrPtr] <= cmdWord;
    end

    // The depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (enq)     wrPtr <= wrPtr + PTR_W'(1);
            if (takeCmd) rdPtr <= rdPtr + PTR_W'(1);
            case ({enq, takeCmd})
                2'b10:   fifoCount <= fifoCount + (PTR_W+1)'(1);
                2'b01:   fifoCount <= fifoCount - (PTR_W+1)'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end
`else
    // Without the FIFO, the accepted command goes straight into the command
    // register. The command is refused while the ALU reports off, because
    // that cycle aborts to PWRUP. The FIFO_DEPTH term is always true for any
    // legal depth; the depth has no other effect in this build.
    assign cmd_ready = !rstQ && (state == IDLE) && !aluOff && (FIFO_DEPTH > 0);
    assign cmdAvail  = cmd_valid && cmd_ready;
    assign cmdQueued = 1'b0;
    assign headCmd   = cmdWord;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= PWRUP;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        takeCmd   = 1'b0;
        case (state)
            PWRUP:   if (!rstQ && alu_state == ALU_READY) nextState = IDLE;
            IDLE: begin
                if (aluOff) begin
                    nextState = PWRUP;
                end else if (cmdAvail) begin
                    nextState = ISSUE;
                    takeCmd   = 1'b1;
                end
            end
            ISSUE:   nextState = aluOff ? PWRUP : CAPTURE;
            CAPTURE: nextState = aluOff ? PWRUP : CHECK;
            CHECK:   nextState = aluOff ? PWRUP : DONE;
            DONE: begin
                if (aluOff) begin
                    nextState = PWRUP;
                end else if (cmdAvail) begin
                    nextState = ISSUE;
                    takeCmd   = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = PWRUP;
        endcase
    end

    assign opA      = curChain ? chainQ : curA;
    assign opSel    = (curOp == OP_CLEAR) ? 7'b0 : (7'b1000000 >> curOp);
    assign res_data = resDataQ;
    assign res_err  = resErrQ;

    // All ALU drive stays low for the cycle after any reset edge. The ALU is
    // only powered once the first clock edge with rst low has been seen.
    always_comb begin
        alu_on      = 1'b0;
        alu_in_sel  = 3'b000;
        alu_num1    = 8'h00;
        alu_num2    = 8'h00;
        alu_out_sel = 7'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        if (!rstQ) begin
            alu_on = 1'b1;
            case (state)
                PWRUP: alu_in_sel = 3'b001;
                IDLE:  busy = cmdQueued;
                ISSUE: begin
                    alu_in_sel  = (curOp == OP_CLEAR) ? 3'b001 : 3'b010;
                    alu_num1    = opA;
                    alu_num2    = curB;
                    alu_out_sel = opSel;
                end
                CAPTURE, CHECK: begin
                    alu_num1    = opA;
                    alu_num2    = curB;
                    alu_out_sel = opSel;
                end
                DONE:    res_valid = !aluOff;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstQ     <= 1'b1;
            curOp    <= 3'd0;
            curChain <= 1'b0;
            curA     <= 8'h00;
            curB     <= 8'h00;
            captureQ <= 8'h00;
            resDataQ <= 8'h00;
            resErrQ  <= 1'b0;
            chainQ   <= 8'h00;
        end else begin
            rstQ <= 1'b0;
            if (takeCmd) {curOp, curChain, curA, curB} <= headCmd;
            if (state == CAPTURE) captureQ <= (curOp == OP_CLEAR) ? 8'h00 : alu_result;
            // A failed operation must not feed a later chained command.
            if (state == CHECK && nextState == DONE) begin
                resDataQ <= captureQ;
                resErrQ  <= (alu_state == ALU_RUN_ERR);
                chainQ   <= (alu_state == ALU_RUN_ERR) ? 8'h00 : captureQ;
            end
        end
    end

endmodule
